// File: rtl/outbuf_drain_if.sv
// Bundles the output-FIFO read port and the result stream of the drain block.
// The master modport is the drain side. The slave modport is the FIFO/consumer side.

interface outbuf_drain_if #(
  parameter int DATA_WIDTH = 17,
  parameter int PAR_READ   = 2
);
  // FIFO side: outbuf_dout is valid whenever !outbuf_empty, and outbuf_ren pops at that edge.
  // Stream side: a word transfers on a rising edge with m_valid & m_ready both high.
  // While m_valid is high and m_ready is low, m_data and m_last hold stable.
  logic                           outbuf_empty;
  logic [PAR_READ*DATA_WIDTH-1:0] outbuf_dout;
  logic                           outbuf_ren;
  logic                           m_valid;
  logic                           m_ready;
  logic [DATA_WIDTH-1:0]          m_data;
  logic                           m_last;

  modport master (
    input  outbuf_empty, outbuf_dout, m_ready,
    output outbuf_ren, m_valid, m_data, m_last
  );

  modport slave (
    output outbuf_empty, outbuf_dout, m_ready,
    input  outbuf_ren, m_valid, m_data, m_last
  );
endinterface

// File: rtl/outbuf_drain.sv
// Drains PAR_READ-word groups from the output FIFO and serialises them lane 0 first
// onto a valid/ready stream, flagging the last word and pulsing done at the end.

module outbuf_drain #(
  parameter int DATA_WIDTH = 17,
  parameter int PAR_READ   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] expected_cnt,
  outbuf_drain_if.master       bus,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           o_dbg_state
);

  localparam int IDX_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t                         r_state;
  logic [CNT_WIDTH-1:0]           r_remaining;
  logic [IDX_W-1:0]               r_idx;
  logic [PAR_READ*DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0]          r_m_data;
  logic                           r_m_valid;
  logic                           r_m_last;
  logic                           r_busy;
  logic                           r_done;

  logic [DATA_WIDTH-1:0]          w_lane [PAR_READ];
  logic [IDX_W-1:0]               w_idx_nxt;
  logic                           w_ren;
  logic                           w_fire;
  logic                           w_last_lane;
  logic                           w_final_word;

  for (genvar k = 0; k < PAR_READ; k++) begin : g_lane
    assign w_lane[k] = r_hold[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // The pop is combinational so that a fall-through FIFO can pop in the same cycle it turns non-empty.
  assign w_ren        = (r_state == S_FETCH) && !bus.outbuf_empty;
  assign w_fire       = r_m_valid && bus.m_ready;
  assign w_idx_nxt    = r_idx + IDX_W'(1);
  assign w_last_lane  = (r_idx == IDX_W'(PAR_READ - 1));
  assign w_final_word = (r_remaining == CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_idx       <= '0;
      r_hold      <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (expected_cnt != '0) begin
              r_remaining <= expected_cnt;
              r_state     <= S_FETCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_FETCH: begin
          if (w_ren) begin
            r_hold    <= bus.outbuf_dout;
            r_idx     <= '0;
            r_m_data  <= bus.outbuf_dout[DATA_WIDTH-1:0];
            r_m_valid <= 1'b1;
            r_m_last  <= w_final_word;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_fire) begin
            r_remaining <= r_remaining - CNT_WIDTH'(1);
            // The count ends the run even in mid-group, so unsent lanes of the last group are dropped.
            if (w_final_word) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_FIN;
            end else if (w_last_lane) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_state   <= S_FETCH;
            end else begin
              r_idx    <= w_idx_nxt;
              r_m_data <= w_lane[w_idx_nxt];
              r_m_last <= (r_remaining == CNT_WIDTH'(2));
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.outbuf_ren = w_ren;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_data     = r_m_data;
  assign bus.m_last     = r_m_last;
  assign busy           = r_busy;
  assign done           = r_done;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_outbuf_drain.sv
// Bench for outbuf_drain. It uses cycle vectors for the basic runs, hand-written corner sequences,
// and randomised runs that are checked against a queue-level model of what a run must deliver.

module tb_outbuf_drain;
  localparam int DW = 17;
  localparam int PR = 2;
  localparam int CW = 16;
  localparam int GW = DW * PR;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] expected_cnt = '0;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  outbuf_drain_if #(.DATA_WIDTH(DW), .PAR_READ(PR)) bus ();

  outbuf_drain #(.DATA_WIDTH(DW), .PAR_READ(PR), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .expected_cnt (expected_cnt),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [GW-1:0] fifo_q[$];   // what the FIFO really holds
  logic [GW-1:0] ref_q[$];    // model view: every group pushed, removed by run rules
  logic [GW-1:0] pend_q[$];   // groups scheduled for late push
  logic [DW-1:0] got_q[$];
  bit            got_last[$];
  logic [DW-1:0] exp_q[$];
  int            pop_cnt = 0;
  int            done_cnt = 0;
  bit            rand_ready = 1'b0;

  typedef struct {
    bit          start;
    bit          ready;
    bit          ren;
    bit          valid;
    logic [DW-1:0] data;
    bit          last;
    bit          busy;
    bit          done;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_fifo();
    bus.outbuf_empty = (fifo_q.size() == 0);
    bus.outbuf_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_grp(input logic [GW-1:0] g);
    fifo_q.push_back(g);
    ref_q.push_back(g);
    drive_fifo();
  endtask

  function automatic logic [GW-1:0] mk_grp(input logic [DW-1:0] l0, input logic [DW-1:0] l1);
    return {l1, l0};
  endfunction

  function automatic logic [GW-1:0] rnd_grp();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[GW-1:0];
  endfunction

  // One clock: monitor pre-edge values, then apply the FIFO pop the DUT requested.
  task automatic step();
    bit r;
    #1;
    r = bus.outbuf_ren;
    if (bus.m_valid && bus.m_ready) begin
      got_q.push_back(bus.m_data);
      got_last.push_back(bus.m_last);
    end
    if (done) done_cnt++;
    @(posedge clk);
    #1;
    if (r) begin
      pop_cnt++;
      if (fifo_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_empty: got ren=1 expected ren=0 while FIFO empty");
      end else begin
        void'(fifo_q.pop_front());
      end
    end
    drive_fifo();
  endtask

  task automatic begin_run();
    got_q.delete();
    got_last.delete();
    pop_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start(input int n);
    expected_cnt = CW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      bus.m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pend_q.size() != 0 && $urandom_range(0, 2) == 0) push_grp(pend_q.pop_front());
      step();
      cyc++;
    end
    if (done_cnt == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 300 cycles", tag);
    end
    bus.m_ready = 1'b1;
    step();
    while (pend_q.size() != 0) push_grp(pend_q.pop_front());
  endtask

  // Model: a run of n words pops ceil(n/PR) groups and delivers their first n lanes in order.
  task automatic check_run(input int n, input string tag);
    int p;
    logic [GW-1:0] g;
    p = (n + PR - 1) / PR;
    exp_q.delete();
    for (int gi = 0; gi < p; gi++) begin
      if (ref_q.size() == 0) break;
      g = ref_q.pop_front();
      for (int k = 0; k < PR; k++)
        if (exp_q.size() < n) exp_q.push_back(g[k*DW +: DW]);
    end
    chk($sformatf("%s_nwords", tag), got_q.size(), n);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == n - 1));
    end
    chk($sformatf("%s_pops", tag), pop_cnt, p);
    chk($sformatf("%s_done", tag), done_cnt, 1);
    chk($sformatf("%s_fifo_left", tag), fifo_q.size(), ref_q.size());
  endtask

  function automatic vec_t v(bit s, bit rd, bit ren, bit vl, logic [DW-1:0] d, bit l, bit b, bit dn);
    vec_t x;
    x.start = s; x.ready = rd; x.ren = ren; x.valid = vl;
    x.data = d; x.last = l; x.busy = b; x.done = dn;
    return x;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    bus.m_ready = 1'b1;
    drive_fifo();

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ren", bus.outbuf_ren, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_last", bus.m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // T1 and T2 as cycle vectors: {start, ready, ren, valid, data, last, busy, done}
    vt.push_back(v(1,1, 0,0,'h000,0,0,0));
    vt.push_back(v(0,1, 1,0,'h000,0,1,0));
    vt.push_back(v(0,1, 0,1,'h011,0,1,0));
    vt.push_back(v(0,1, 0,1,'h022,0,1,0));
    vt.push_back(v(0,1, 1,0,'h000,0,1,0));
    vt.push_back(v(0,1, 0,1,'h033,0,1,0));
    vt.push_back(v(0,1, 0,1,'h044,1,1,0));
    vt.push_back(v(0,1, 0,0,'h000,0,1,1));
    vt.push_back(v(0,1, 0,0,'h000,0,0,0));
    vt.push_back(v(1,1, 0,0,'h000,0,0,0));
    vt.push_back(v(0,1, 1,0,'h000,0,1,0));
    vt.push_back(v(0,1, 0,1,'h011,0,1,0));
    vt.push_back(v(0,0, 0,1,'h022,0,1,0));
    vt.push_back(v(0,0, 0,1,'h022,0,1,0));
    vt.push_back(v(0,0, 0,1,'h022,0,1,0));
    vt.push_back(v(0,1, 0,1,'h022,0,1,0));
    vt.push_back(v(0,1, 1,0,'h000,0,1,0));
    vt.push_back(v(0,1, 0,1,'h033,0,1,0));
    vt.push_back(v(0,1, 0,1,'h044,1,1,0));
    vt.push_back(v(0,1, 0,0,'h000,0,1,1));
    vt.push_back(v(0,1, 0,0,'h000,0,0,0));

    for (int r = 0; r < 2; r++) begin
      push_grp(mk_grp('h011, 'h022));
      push_grp(mk_grp('h033, 'h044));
    end
    expected_cnt = CW'(4);
    begin_run();
    for (int i = 0; i < vt.size(); i++) begin
      if (i == 9) begin
        check_run(4, "t1");
        begin_run();
      end
      start = vt[i].start;
      bus.m_ready = vt[i].ready;
      #1;
      chk($sformatf("vec%0d_ren", i), bus.outbuf_ren, vt[i].ren);
      chk($sformatf("vec%0d_valid", i), bus.m_valid, vt[i].valid);
      if (vt[i].valid) begin
        chk($sformatf("vec%0d_data", i), bus.m_data, vt[i].data);
        chk($sformatf("vec%0d_last", i), bus.m_last, vt[i].last);
      end
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("vec%0d_done", i), done, vt[i].done);
      step();
    end
    start = 1'b0;
    check_run(4, "t2");

    // T3: partial final group, where the second lane of the second group is discarded
    push_grp(mk_grp('h011, 'h022));
    push_grp(mk_grp('h033, 'h044));
    begin_run();
    pulse_start(3);
    finish_run("t3");
    check_run(3, "t3");

    // T4: the run starts with the FIFO empty
    begin_run();
    pulse_start(2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t4_wait%0d_ren", i), bus.outbuf_ren, 0);
      chk($sformatf("t4_wait%0d_valid", i), bus.m_valid, 0);
      chk($sformatf("t4_wait%0d_busy", i), busy, 1);
      step();
    end
    push_grp(mk_grp('h155, 'h0AA));
    #1;
    chk("t4_ren_same_cycle", bus.outbuf_ren, 1);
    step();
    #1;
    chk("t4_valid_next", bus.m_valid, 1);
    chk("t4_data_next", bus.m_data, 'h155);
    finish_run("t4");
    check_run(2, "t4");

    // T5: a zero count gives only a done pulse
    begin_run();
    pulse_start(0);
    #1;
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 1);
    chk("t5_ren", bus.outbuf_ren, 0);
    chk("t5_valid", bus.m_valid, 0);
    step();
    #1;
    chk("t5_done_clear", done, 0);
    chk("t5_busy_clear", busy, 0);
    chk("t5_pops", pop_cnt, 0);

    // T6: reset in the middle of SEND, where the popped group is lost
    push_grp(mk_grp('h101, 'h102));
    push_grp(mk_grp('h103, 'h104));
    begin_run();
    pulse_start(4);
    step();
    chk("t6_in_send", bus.m_valid, 1);
    chk("t6_pops_before_rst", pop_cnt, 1);
    void'(ref_q.pop_front());
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", bus.m_valid, 0);
    chk("t6_rst_data", bus.m_data, 0);
    chk("t6_rst_ren", bus.outbuf_ren, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_state", dbg_state, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    drive_fifo();
    begin_run();
    pulse_start(2);
    finish_run("t6");
    check_run(2, "t6");

    // Randomised runs with late pushes and downstream stalls
    for (int it = 0; it < 25; it++) begin
      int n, p, pre;
      n = $urandom_range(0, 9);
      p = (n + PR - 1) / PR;
      pre = $urandom_range(0, p);
      for (int g = 0; g < pre; g++) push_grp(rnd_grp());
      for (int g = pre; g < p + $urandom_range(0, 1); g++) pend_q.push_back(rnd_grp());
      rand_ready = 1'b1;
      begin_run();
      pulse_start(n);
      finish_run($sformatf("rnd%0d", it));
      check_run(n, $sformatf("rnd%0d", it));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
